// File: rtl/laser_lanes_obstacle.sv
// Lane laser obstacle: each shot warns, grows and fires, then moves to the next lane.
// Build option: define LASER_LFSR_ORDER_EN to pick lanes with an 8-bit LFSR instead of ping-pong.
module laser_lanes_obstacle #(
  parameter int          N_LANES      = 3,
  parameter int          ORIENT       = 0,
  parameter int          FIRST_CENTER = 367,
  parameter int          LANE_PITCH   = 100,
  parameter int          SPAN_START   = 361,
  parameter int          SPAN_END     = 661,
  parameter int          MAX_HALF     = 30,
  parameter int          HOLD_CYCLES  = 32000000,
  parameter int          GROW_CYCLES  = 3200000,
  parameter int          FIRE_CYCLES  = 32000000,
  parameter int          N_SHOTS      = 16,
  parameter logic [3:0]  SEL_CODE     = 4'b0010,
  parameter logic [11:0] WARN_RGB     = 12'h844,
  parameter logic [11:0] ACTIVE_RGB   = 12'hfff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] rgb_in,
  input  logic        menu_on,
  input  logic        play_selected,
  input  logic [3:0]  selected,
  input  logic        done_in,
  output logic [11:0] rgb_out,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y,
  output logic        working,
  output logic        done,
  output logic [2:0]  lane_idx
);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GROW_LAST = 32'(GROW_CYCLES - 1);
  localparam logic [31:0] FIRE_LAST = 32'(FIRE_CYCLES - 1);
  localparam logic [11:0] HALF_FULL = 12'(MAX_HALF);
  localparam logic [15:0] SHOTS     = 16'(N_SHOTS);
  localparam logic [2:0]  LAST_LANE = 3'(N_LANES - 1);
  localparam logic [11:0] SPAN_LO   = 12'(SPAN_START);
  localparam logic [11:0] SPAN_HI   = 12'(SPAN_END);

  typedef enum logic [1:0] {S_IDLE, S_WARN, S_GROW, S_FIRE} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_timer, w_timer_next;
  logic [11:0] r_half, w_half_next;
  logic [15:0] r_shot_cnt, w_shot_next;
  logic [2:0]  r_lane, w_lane_next;
  logic        r_dir, w_dir_next;
  logic [11:0] r_rgb, w_rgb_next;
  logic [11:0] r_obs_x, w_obs_x_next;
  logic [11:0] r_obs_y, w_obs_y_next;
  logic        r_working, r_done, w_done_next;
  logic        w_start, w_abort;
  logic [2:0]  w_step_lane;
  logic        w_step_dir;
  logic [11:0] w_center, w_lo, w_cross, w_along;
  logic [12:0] w_hi;
  logic        w_in_laser;

  assign w_start = done_in && play_selected && (selected == SEL_CODE);
  assign w_abort = menu_on || !play_selected;

  generate
    if (ORIENT == 0) begin : g_horiz
      assign w_cross = vcount_in;
      assign w_along = hcount_in;
    end else begin : g_vert
      assign w_cross = hcount_in;
      assign w_along = vcount_in;
    end
  endgenerate

  // Lower bound saturates at 0; upper bound is carried in 13 bits so it never wraps.
  assign w_center   = 12'(FIRST_CENTER + int'(r_lane) * LANE_PITCH);
  assign w_lo       = (w_center >= r_half) ? (w_center - r_half) : 12'd0;
  assign w_hi       = {1'b0, w_center} + {1'b0, r_half} + 13'd1;
  assign w_in_laser = (w_cross >= w_lo) && ({1'b0, w_cross} <= w_hi) &&
                      (w_along >= SPAN_LO) && (w_along <= SPAN_HI);

`ifdef LASER_LFSR_ORDER_EN
  logic [7:0] r_lfsr, w_lfsr_adv;
  logic [2:0] w_rand_lane;
  logic       w_shot_done;

  assign w_shot_done = (r_state == S_FIRE) && (r_timer == FIRE_LAST) && !w_abort;
  assign w_lfsr_adv  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_rand_lane = 3'(w_lfsr_adv % 8'(N_LANES));
  assign w_step_lane = (w_rand_lane == r_lane) ? 3'((int'(r_lane) + 1) % N_LANES) : w_rand_lane;
  assign w_step_dir  = r_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 8'h01;
    end else if (w_shot_done) begin
      r_lfsr <= w_lfsr_adv;
    end
  end
`else
  // Ping-pong: r_dir = 0 walks up, 1 walks down, reversing at either end.
  always_comb begin
    w_step_lane = r_lane;
    w_step_dir  = r_dir;
    if (N_LANES <= 1) begin
      w_step_lane = 3'd0;
    end else if (!r_dir) begin
      if (r_lane == LAST_LANE) begin
        w_step_lane = r_lane - 3'd1;
        w_step_dir  = 1'b1;
      end else begin
        w_step_lane = r_lane + 3'd1;
      end
    end else begin
      if (r_lane == 3'd0) begin
        w_step_lane = 3'd1;
        w_step_dir  = 1'b0;
      end else begin
        w_step_lane = r_lane - 3'd1;
      end
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_half_next  = r_half;
    w_shot_next  = r_shot_cnt;
    w_lane_next  = r_lane;
    w_dir_next   = r_dir;
    w_done_next  = 1'b0;
    w_rgb_next   = rgb_in;
    w_obs_x_next = 12'd0;
    w_obs_y_next = 12'd0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_WARN;
          w_timer_next = 32'd0;
          w_half_next  = 12'd0;
          w_shot_next  = 16'd0;
          w_lane_next  = 3'd0;
          w_dir_next   = 1'b0;
        end
      end
      S_WARN: begin
        if (r_timer == HOLD_LAST) begin
          w_state_next = S_GROW;
          w_timer_next = 32'd0;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      S_GROW: begin
        if (r_timer == GROW_LAST) begin
          w_timer_next = 32'd0;
          w_half_next  = r_half + 12'd1;
          if (w_half_next == HALF_FULL) w_state_next = S_FIRE;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      S_FIRE: begin
        if (r_timer == FIRE_LAST) begin
          w_timer_next = 32'd0;
          w_shot_next  = r_shot_cnt + 16'd1;
          if (w_shot_next == SHOTS) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_WARN;
            w_half_next  = 12'd0;
            w_lane_next  = w_step_lane;
            w_dir_next   = w_step_dir;
          end
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if ((r_state != S_IDLE) && w_abort) begin
      w_state_next = S_IDLE;
      w_done_next  = 1'b0;
    end

    if (w_in_laser) begin
      if (r_state == S_WARN) begin
        w_rgb_next = WARN_RGB;
      end else if ((r_state == S_GROW) || (r_state == S_FIRE)) begin
        w_rgb_next   = ACTIVE_RGB;
        w_obs_x_next = hcount_in;
        w_obs_y_next = vcount_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= 32'd0;
      r_half     <= 12'd0;
      r_shot_cnt <= 16'd0;
      r_lane     <= 3'd0;
      r_dir      <= 1'b0;
      r_rgb      <= 12'd0;
      r_obs_x    <= 12'd0;
      r_obs_y    <= 12'd0;
      r_working  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_half     <= w_half_next;
      r_shot_cnt <= w_shot_next;
      r_lane     <= w_lane_next;
      r_dir      <= w_dir_next;
      r_rgb      <= w_rgb_next;
      r_obs_x    <= w_obs_x_next;
      r_obs_y    <= w_obs_y_next;
      r_working  <= (w_state_next != S_IDLE);
      r_done     <= w_done_next;
    end
  end

  assign rgb_out    = r_rgb;
  assign obstacle_x = r_obs_x;
  assign obstacle_y = r_obs_y;
  assign working    = r_working;
  assign done       = r_done;
  assign lane_idx   = r_lane;
endmodule

// File: tb/tb_laser_lanes_obstacle.sv
// Randomised bench for laser_lanes_obstacle against a schedule-based reference model.
// Honours LASER_LFSR_ORDER_EN for the expected lane order.
module tb_laser_lanes_obstacle;
  localparam int NL = 3, HOLD = 4, GROW = 2, FIRE = 4, MH = 3, NS = 4;
  localparam int PERIOD = HOLD + GROW * MH + FIRE;
  localparam int TOTAL  = PERIOD * NS;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, rgb_in;
  logic        menu_on, play_selected, done_in;
  logic [3:0]  selected;
  logic [11:0] rgb_out, obstacle_x, obstacle_y;
  logic        working, done;
  logic [2:0]  lane_idx;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a run is a fixed schedule of TOTAL cycles indexed by m_tick.
  bit m_run;
  int m_tick, m_lane, m_lfsr;

  laser_lanes_obstacle #(
    .N_LANES(NL), .HOLD_CYCLES(HOLD), .GROW_CYCLES(GROW),
    .FIRE_CYCLES(FIRE), .MAX_HALF(MH), .N_SHOTS(NS)
  ) dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .rgb_in(rgb_in), .menu_on(menu_on), .play_selected(play_selected),
    .selected(selected), .done_in(done_in), .rgb_out(rgb_out),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y), .working(working),
    .done(done), .lane_idx(lane_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pingpong(int k);
    int m;
    if (NL == 1) return 0;
    m = k % (2 * (NL - 1));
    return (m < NL) ? m : 2 * (NL - 1) - m;
  endfunction

  function automatic int lfsr_step(int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  // Expected {rgb, x, y} for a pixel given phase (0 idle,1 warn,2 grow,3 fire).
  function automatic logic [35:0] pix(int st, int lane, int half, int h, int v, logic [11:0] rgb);
    int c, lo, hi;
    bit inside_l;
    c  = (367 + lane * 100) % 4096;
    lo = (c >= half) ? c - half : 0;
    hi = c + 1 + half;
    inside_l = (v >= lo) && (v <= hi) && (h >= 361) && (h <= 661);
    if (inside_l && st == 1) return {12'h844, 24'd0};
    if (inside_l && st >= 2) return {12'hfff, 12'(h), 12'(v)};
    return {rgb, 24'd0};
  endfunction

  task automatic step(input int h, input int v, input logic [11:0] rgb,
                      input logic d, input logic mn, input logic pl, input logic [3:0] sel);
    int st, half, p;
    logic [35:0] e_pix;
    logic e_done;
    hcount_in = 12'(h); vcount_in = 12'(v); rgb_in = rgb;
    done_in = d; menu_on = mn; play_selected = pl; selected = sel;
    st = 0; half = 0;
    if (m_run) begin
      p = m_tick % PERIOD;
      if (p < HOLD) st = 1;
      else if (p < HOLD + GROW * MH) begin st = 2; half = (p - HOLD) / GROW; end
      else begin st = 3; half = MH; end
    end
    e_pix  = pix(st, m_lane, half, h, v, rgb);
    e_done = 1'b0;
    if (m_run) begin
      if (mn || !pl) m_run = 0;
      else begin
        m_tick++;
        if (m_tick % PERIOD == 0) begin
`ifdef LASER_LFSR_ORDER_EN
          m_lfsr = lfsr_step(m_lfsr);
          if (m_lfsr % NL == m_lane) m_lane = (m_lane + 1) % NL;
          else m_lane = m_lfsr % NL;
`else
          m_lane = pingpong(m_tick / PERIOD);
`endif
        end
        if (m_tick == TOTAL) begin m_run = 0; e_done = 1'b1; end
      end
    end else if (d && pl && sel == 4'd2) begin
      m_run = 1; m_tick = 0; m_lane = 0;
    end
    @(posedge clk); #1;
    chk("rgb_out", 32'(rgb_out), 32'(e_pix[35:24]));
    chk("obstacle_x", 32'(obstacle_x), 32'(e_pix[23:12]));
    chk("obstacle_y", 32'(obstacle_y), 32'(e_pix[11:0]));
    chk("working", 32'(working), 32'(m_run));
    chk("done", 32'(done), 32'(e_done));
    if (m_run) chk("lane_idx", 32'(lane_idx), 32'(m_lane));
    $display("tick=%0d run=%0d h=%0d v=%0d rgb_out=%h obs=(%0d,%0d) work=%0b done=%0b lane=%0d",
             m_tick, m_run, h, v, rgb_out, obstacle_x, obstacle_y, working, done, lane_idx);
  endtask

  task automatic rnd_step(input logic pl);
    logic d;
    d = m_run ? 1'($urandom_range(0, 1)) : 1'b0;
    step(int'($urandom_range(330, 700)), int'($urandom_range(355, 580)),
         12'($urandom_range(0, 4095)), d, 1'b0, pl, 4'd2);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_run && m_tick != target && n < 200) begin
      rnd_step(1'b1);
      n++;
    end
    if (n >= 200) chk("run_timeout", 32'(n), 32'd0);
  endtask

  task automatic start_run();
    step(400, 367, 12'h0a5, 1'b1, 1'b0, 1'b1, 4'd2);
  endtask

  task automatic reset_checks();
    chk("rst_rgb_out", 32'(rgb_out), 32'd0);
    chk("rst_obstacle_x", 32'(obstacle_x), 32'd0);
    chk("rst_obstacle_y", 32'(obstacle_y), 32'd0);
    chk("rst_working", 32'(working), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lane_idx", 32'(lane_idx), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; rgb_in = '0;
    menu_on = 1'b0; play_selected = 1'b0; done_in = 1'b0; selected = 4'd0;
    m_run = 0; m_tick = 0; m_lane = 0; m_lfsr = 1;
    #3;
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;

    // No start with wrong selector or without play selected.
    step(400, 367, 12'h123, 1'b1, 1'b0, 1'b1, 4'd3);
    step(400, 367, 12'h124, 1'b1, 1'b0, 1'b0, 4'd2);

    // Full run: warning pixel, full-size edge pixels, then completion.
    start_run();
    step(400, 367, 12'h321, 1'b0, 1'b0, 1'b1, 4'd2);
    run_to(HOLD + GROW * MH);
    step(400, 364, 12'h456, 1'b0, 1'b0, 1'b1, 4'd2);
    step(400, 363, 12'h457, 1'b0, 1'b0, 1'b1, 4'd2);
    run_to(-1);
    repeat (3) rnd_step(1'b1);

    // Abort by menu during the second shot's growth.
    start_run();
    run_to(PERIOD + HOLD + 1);
    step(400, 467, 12'h777, 1'b0, 1'b1, 1'b1, 4'd2);
    repeat (3) step(400, 467, 12'h778, 1'b0, 1'b0, 1'b1, 4'd2);

    // Abort by dropping play_selected.
    start_run();
    run_to(2 * PERIOD + 2);
    step(400, 567, 12'h779, 1'b0, 1'b0, 1'b0, 4'd2);
    repeat (2) rnd_step(1'b1);

    // Asynchronous reset in the middle of the second shot's FIRE.
    start_run();
    run_to(PERIOD + HOLD + GROW * MH + 1);
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    m_run = 0; m_tick = 0; m_lane = 0; m_lfsr = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    rnd_step(1'b1);
    start_run();
    run_to(-1);
    repeat (2) rnd_step(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
